// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for the FIFO serial transmitter: widths, frame constants, FSM encoding.
package fifo_serial_tx_pkg;

  localparam int unsigned DATA_W     = 4;
  localparam int unsigned START_BITS = 1;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned BAUD_W     = 8;
  localparam int unsigned BIT_CNT_W  = 2;
  localparam int unsigned FRAMES_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Number of serial bit slots in one frame.
  function automatic int unsigned frame_bits(input bit parity_en);
    return START_BITS + DATA_W + 32'(parity_en) + STOP_BITS;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read port plus serial-line status bundle seen by the transmitter.
interface fifo_serial_tx_if;
  import fifo_serial_tx_pkg::*;

  logic                tx_en;
  logic                empty;
  logic [DATA_W-1:0]   d_out;
  logic                rd_req;
  logic                tx;
  logic                busy;
  logic                frame_done;
  logic [FRAMES_W-1:0] frames_sent;

  // Transmitter side.
  modport master (
    input  tx_en, empty, d_out,
    output rd_req, tx, busy, frame_done, frames_sent
  );

  // FIFO / board side.
  modport slave (
    output tx_en, empty, d_out,
    input  rd_req, tx, busy, frame_done, frames_sent
  );

endinterface

// File: rtl/fifo_serial_tx_baud_tick.sv
// Bit-period timer: down-counter that reloads at terminal count or on clear.
module fifo_serial_tx_baud_tick
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_d,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tick_nxt_c
);

  localparam logic [BAUD_W-1:0] LOAD_VAL = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] cnt;
  logic [BAUD_W-1:0] cnt_nxt;

  // Next count: restart the period on clear or after the terminal cycle.
  always_comb begin
    cnt_nxt = cnt;
    if (clr || (cnt == '0)) begin
      cnt_nxt = LOAD_VAL;
    end else begin
      cnt_nxt = cnt - BAUD_W'(1);
    end
    tick_nxt_c = (cnt_nxt == '0);
  end

  // Count register and registered terminal-count flag.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      cnt  <= LOAD_VAL;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= tick_nxt_c;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the FIFO and sends each as start/data/parity/stop on tx.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b1
) (
  input logic              clk_d,
  input logic              rst,
  fifo_serial_tx_if.master bus
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_W-1:0]     shift;
  logic [DATA_W-1:0]     shift_nxt;
  logic                  parity;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [FRAMES_W-1:0]   frames_sent;
  logic                  baud_clr;
  logic                  tick;
  logic                  tick_nxt_c;
  logic                  rd_req_d;
  logic                  tx_d;
  logic                  busy_d;
  logic                  frame_done_d;

  // Every state change restarts the bit-period timer.
  assign baud_clr = (state_nxt != state);

  fifo_serial_tx_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk_d      (clk_d),
    .rst        (rst),
    .clr        (baud_clr),
    .tick       (tick),
    .tick_nxt_c (tick_nxt_c)
  );

  // State register.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; enable and empty only matter when idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.tx_en && !bus.empty) state_nxt = ST_REQ;
      end
      ST_REQ:  state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_START;
      ST_START: begin
        if (tick) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (tick && (bit_cnt == LAST_BIT)) begin
          state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift register next value: load in LOAD, shift right at each data bit end.
  always_comb begin
    shift_nxt = shift;
    if (state == ST_LOAD) begin
      shift_nxt = bus.d_out;
    end else if ((state == ST_DATA) && tick) begin
      shift_nxt = {1'b0, shift[DATA_W-1:1]};
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    rd_req_d     = 1'b0;
    tx_d         = 1'b1;
    busy_d       = (state_nxt != ST_IDLE);
    frame_done_d = 1'b0;
    case (state_nxt)
      ST_REQ:    rd_req_d     = 1'b1;
      ST_START:  tx_d         = 1'b0;
      ST_DATA:   tx_d         = shift_nxt[0];
      ST_PARITY: tx_d         = parity;
      ST_STOP:   frame_done_d = tick_nxt_c;
      default:   tx_d         = 1'b1;
    endcase
  end

  // Datapath: shift register, parity, data bit index and frame counter.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      shift       <= '0;
      parity      <= 1'b0;
      bit_cnt     <= '0;
      frames_sent <= '0;
    end else begin
      shift <= shift_nxt;
      if (state == ST_LOAD) begin
        parity <= ^bus.d_out;
      end
      if (state != ST_DATA) begin
        bit_cnt <= '0;
      end else if (tick) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
      if ((state == ST_STOP) && tick) begin
        frames_sent <= frames_sent + FRAMES_W'(1);
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      bus.rd_req     <= 1'b0;
      bus.tx         <= 1'b1;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.rd_req     <= rd_req_d;
      bus.tx         <= tx_d;
      bus.busy       <= busy_d;
      bus.frame_done <= frame_done_d;
    end
  end

  assign bus.frames_sent = frames_sent;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench: two transmitters (parity on / off) at 4 clocks per bit, FIFO modelled by a queue.
module tb_fifo_serial_tx;

  logic       clk_d = 1'b0;
  logic       rst;
  logic       push_v;
  logic [3:0] push_d;
  logic [3:0] pop_w;
  logic [3:0] fq[$];

  int total = 0;
  int bad = 0;
  int rdreq_cnt = 0;
  int fd_cnt = 0;
  int rd_when_empty = 0;
  int underflow = 0;

  fifo_serial_tx_if bus_a();
  fifo_serial_tx_if bus_b();

  fifo_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_a (
    .clk_d (clk_d),
    .rst   (rst),
    .bus   (bus_a)
  );

  fifo_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_b (
    .clk_d (clk_d),
    .rst   (rst),
    .bus   (bus_b)
  );

  always #5 clk_d = ~clk_d;

  // FIFO model: read data appears the cycle after rd_req is sampled.
  always @(posedge clk_d) begin
    if (push_v) fq.push_back(push_d);
    if (bus_a.rd_req === 1'b1) begin
      if (fq.size() == 0) begin
        underflow++;
      end else begin
        pop_w = fq.pop_front();
        bus_a.d_out <= pop_w;
      end
    end
    bus_a.empty <= (fq.size() == 0);
  end

  // Pulse counters for the parity-on instance.
  always @(negedge clk_d) begin
    if (bus_a.rd_req === 1'b1) rdreq_cnt++;
    if (bus_a.frame_done === 1'b1) fd_cnt++;
    if ((bus_a.rd_req === 1'b1) && (bus_a.empty === 1'b1)) rd_when_empty++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line sequence, bit slot i at index i: start, d0..d3, even parity, stop.
  function automatic logic [6:0] frame_exp(input logic [3:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  // Wait for a start bit, then sample mid-slot for nbits slots; optionally drop tx_en at cycle drop_at.
  task automatic get_frame(input bit sel_b, input int nbits, input int drop_at,
                           output logic [6:0] bits, output bit fd_ok, output int wait_n);
    logic fd;
    bit   fd_early;
    bit   fd_last;
    bits     = '0;
    wait_n   = 0;
    fd_early = 1'b0;
    fd_last  = 1'b0;
    while (((sel_b ? bus_b.tx : bus_a.tx) !== 1'b0) && (wait_n < 1000)) begin
      @(negedge clk_d);
      wait_n++;
    end
    for (int c = 0; c < nbits * 4; c++) begin
      if (c == drop_at) bus_a.tx_en = 1'b0;
      fd = sel_b ? bus_b.frame_done : bus_a.frame_done;
      if ((c % 4) == 2) bits[3'(c / 4)] = sel_b ? bus_b.tx : bus_a.tx;
      if (c == nbits * 4 - 1) fd_last = (fd === 1'b1);
      else if (fd !== 1'b0) fd_early = 1'b1;
      if (c != nbits * 4 - 1) @(negedge clk_d);
    end
    fd_ok = fd_last && !fd_early;
  endtask

  initial begin
    logic [6:0] bits;
    bit         fd_ok;
    int         wn;
    int         base_rd;
    int         base_fd;
    int         wait_cnt;

    rst          = 1'b1;
    push_v       = 1'b1;
    push_d       = 4'b1011;
    bus_a.tx_en  = 1'b1;
    bus_b.tx_en  = 1'b0;
    bus_b.empty  = 1'b1;
    bus_b.d_out  = 4'hF;

    // Reset held two cycles with a word queued and enable high.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_d); #1;
      push_v = 1'b0;
      chk("rst_tx", 32'(bus_a.tx), 32'd1);
      chk("rst_rd_req", 32'(bus_a.rd_req), 32'd0);
      chk("rst_busy", 32'(bus_a.busy), 32'd0);
      chk("rst_frames", 32'(bus_a.frames_sent), 32'd0);
    end
    rst = 1'b0;

    // Single word 1011.
    base_rd = rdreq_cnt;
    base_fd = fd_cnt;
    @(negedge clk_d);
    get_frame(1'b0, 7, -1, bits, fd_ok, wn);
    chk("single_latency", 32'(wn), 32'd3);
    chk("single_bits", 32'(bits), 32'(7'b1110110));
    chk("single_fd", 32'(fd_ok), 32'd1);
    repeat (5) @(negedge clk_d);
    chk("single_rd_pulses", 32'(rdreq_cnt - base_rd), 32'd1);
    chk("single_fd_pulses", 32'(fd_cnt - base_fd), 32'd1);
    chk("single_frames", 32'(bus_a.frames_sent), 32'd1);
    chk("single_idle", 32'(bus_a.busy), 32'd0);

    // Full drain of 1..8 from a fresh reset.
    bus_a.tx_en = 1'b0;
    @(posedge clk_d); #1 rst = 1'b1;
    @(posedge clk_d); #1 rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push_v = 1'b1;
      push_d = 4'(i);
      @(posedge clk_d); #1;
    end
    push_v = 1'b0;
    base_rd = rdreq_cnt;
    base_fd = fd_cnt;
    bus_a.tx_en = 1'b1;
    @(negedge clk_d);
    for (int i = 1; i <= 8; i++) begin
      get_frame(1'b0, 7, -1, bits, fd_ok, wn);
      chk($sformatf("drain_bits_%0d", i), 32'(bits), 32'(frame_exp(4'(i))));
      chk($sformatf("drain_fd_%0d", i), 32'(fd_ok), 32'd1);
      if (i > 1) chk($sformatf("drain_gap_%0d", i), 32'(wn), 32'd4);
    end
    repeat (10) @(negedge clk_d);
    chk("drain_rd_pulses", 32'(rdreq_cnt - base_rd), 32'd8);
    chk("drain_fd_pulses", 32'(fd_cnt - base_fd), 32'd8);
    chk("drain_rd_when_empty", 32'(rd_when_empty), 32'd0);
    chk("drain_underflow", 32'(underflow), 32'd0);
    chk("drain_frames", 32'(bus_a.frames_sent), 32'd8);

    // Parity disabled, word F.
    @(posedge clk_d); #1;
    bus_b.empty = 1'b0;
    bus_b.tx_en = 1'b1;
    @(posedge clk_d); #1;
    chk("np_rd_req", 32'(bus_b.rd_req), 32'd1);
    bus_b.empty = 1'b1;
    bus_b.tx_en = 1'b0;
    @(negedge clk_d);
    get_frame(1'b1, 6, -1, bits, fd_ok, wn);
    chk("np_bits", 32'(bits[5:0]), 32'(6'b111110));
    chk("np_fd_at_24", 32'(fd_ok), 32'd1);
    repeat (3) @(negedge clk_d);
    chk("np_frames", 32'(bus_b.frames_sent), 32'd1);
    chk("np_idle", 32'(bus_b.busy), 32'd0);

    // Enable gating: three words, tx_en dropped during data of the first.
    bus_a.tx_en = 1'b0;
    @(posedge clk_d); #1;
    push_v = 1'b1; push_d = 4'hA; @(posedge clk_d); #1;
    push_d = 4'h3; @(posedge clk_d); #1;
    push_d = 4'hC; @(posedge clk_d); #1;
    push_v = 1'b0;
    base_rd = rdreq_cnt;
    bus_a.tx_en = 1'b1;
    @(negedge clk_d);
    get_frame(1'b0, 7, 9, bits, fd_ok, wn);
    chk("gate_f1_bits", 32'(bits), 32'(frame_exp(4'hA)));
    chk("gate_f1_fd", 32'(fd_ok), 32'd1);
    repeat (40) @(negedge clk_d);
    chk("gate_held_rd", 32'(rdreq_cnt - base_rd), 32'd1);
    chk("gate_held_busy", 32'(bus_a.busy), 32'd0);
    chk("gate_held_tx", 32'(bus_a.tx), 32'd1);
    bus_a.tx_en = 1'b1;
    get_frame(1'b0, 7, -1, bits, fd_ok, wn);
    chk("gate_f2_bits", 32'(bits), 32'(frame_exp(4'h3)));
    get_frame(1'b0, 7, -1, bits, fd_ok, wn);
    chk("gate_f3_bits", 32'(bits), 32'(frame_exp(4'hC)));
    chk("gate_f3_gap", 32'(wn), 32'd4);
    repeat (5) @(negedge clk_d);
    chk("gate_rd_total", 32'(rdreq_cnt - base_rd), 32'd3);

    // Reset during the parity bit of word 5; word 6 goes next.
    bus_a.tx_en = 1'b0;
    @(posedge clk_d); #1 rst = 1'b1;
    @(posedge clk_d); #1 rst = 1'b0;
    push_v = 1'b1; push_d = 4'h5; @(posedge clk_d); #1;
    push_d = 4'h6; @(posedge clk_d); #1;
    push_v = 1'b0;
    bus_a.tx_en = 1'b1;
    wait_cnt = 0;
    @(negedge clk_d);
    while ((bus_a.tx !== 1'b0) && (wait_cnt < 1000)) begin
      @(negedge clk_d);
      wait_cnt++;
    end
    chk("mid_start_seen", 32'(wait_cnt < 1000), 32'd1);
    repeat (21) @(negedge clk_d);
    chk("mid_parity_bit", 32'(bus_a.tx), 32'd0);
    chk("mid_busy_before", 32'(bus_a.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk_d); #1;
    chk("mid_tx", 32'(bus_a.tx), 32'd1);
    chk("mid_busy", 32'(bus_a.busy), 32'd0);
    chk("mid_frames", 32'(bus_a.frames_sent), 32'd0);
    rst = 1'b0;
    get_frame(1'b0, 7, -1, bits, fd_ok, wn);
    chk("mid_next_bits", 32'(bits), 32'(frame_exp(4'h6)));
    chk("mid_next_fd", 32'(fd_ok), 32'd1);
    repeat (3) @(negedge clk_d);
    chk("mid_next_frames", 32'(bus_a.frames_sent), 32'd1);
    chk("mid_underflow", 32'(underflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
